ghr_checkpoint_unit: RTL and testbench
======================================

Name: ghr_checkpoint_unit

Overview:
- Owns the speculative global history register (GHR) that drives the `GHR` field of `branch_controls_ifc`, which the predictor reads at decode.
- Shifts each accepted decode-stage prediction into the speculative GHR.
- Keeps an in-order FIFO of per-branch checkpoints.
- On execute-stage feedback: retires the oldest checkpoint into the architectural GHR; on a misprediction, restores the speculative GHR from that checkpoint.
- Sits between the decode-stage predictor request and the execute-stage branch result.

Parameters:
- GHR_LEN, 8: history length in bits; must equal the `GHR_LEN` define.
- DEPTH, 4: number of in-flight branch checkpoints (power of 2, ≥2).
- ADDR_WIDTH, 32: PC width; must equal the `ADDR_WIDTH` define.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_pred_valid  in  1  decode presents a conditional-branch prediction.
- i_pred_pc  in  ADDR_WIDTH  PC of the predicted branch.
- i_pred_taken  in  1  predicted direction (1 = TAKEN).
- o_pred_ready  out  1  checkpoint FIFO not full; hazard control stalls decode when 0.
- i_fb_valid  in  1  execute resolves the oldest in-flight branch.
- i_fb_pc  in  ADDR_WIDTH  PC of the resolved branch.
- i_fb_taken  in  1  actual outcome (1 = TAKEN).
- i_flush  in  1  pipeline flush from non-branch causes.
- o_ghr  out  GHR_LEN  speculative GHR, registered; drives `branch_controls_ifc.GHR`.
- o_arch_ghr  out  GHR_LEN  committed GHR, registered.
- o_fb_mispredict  out  1  combinational: i_fb_valid & FIFO non-empty & (i_fb_taken != head.pred).
- o_count  out  $clog2(DEPTH+1)  number of valid checkpoints.
- o_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, any time, including mid-operation):
  - o_ghr = 0, o_arch_ghr = 0, o_count = 0, o_err = 0.
  - FIFO pointers = 0; o_pred_ready = 1.
- Push:
  - push = i_pred_valid & o_pred_ready & ~mispredict & ~i_flush.
  - Entry written at tail = {pc, pred, ghr_before = o_ghr}.
  - Next o_ghr = {o_ghr[GHR_LEN-2:0], i_pred_taken}.
  - Latency 1: a prediction made in cycle N sees o_ghr including branches accepted up to N-1.
- o_pred_ready = (o_count != DEPTH); it has no combinational dependence on feedback. When full, the prediction is not accepted and the state is unchanged.
- Pop:
  - pop = i_fb_valid & (o_count != 0). The head entry is retired.
  - Next o_arch_ghr = {o_arch_ghr[GHR_LEN-2:0], i_fb_taken}.
- Correct prediction: pop only. Simultaneous push and pop leaves o_count unchanged; both pointers advance, wrapping modulo DEPTH.
- Misprediction (pop & head.pred != i_fb_taken):
  - All entries are discarded (head = tail, o_count = 0).
  - Next o_ghr = {head.ghr_before[GHR_LEN-2:0], i_fb_taken}.
  - A push in the same cycle is dropped (wrong path).
- Flush (i_flush, no misprediction):
  - All entries are discarded.
  - Next o_ghr = the next value of o_arch_ghr, so a pop in the same cycle is included.
  - Any push in the same cycle is dropped.
- Priority: rst > misprediction restore > flush > push/pop.
- Invariant in correct operation: head.ghr_before == o_arch_ghr. A misprediction restore therefore equals the updated architectural GHR.
- Errors (sticky until rst; normal processing continues):
  - i_fb_valid with o_count == 0: sets o_err; no state change otherwise.
  - i_fb_pc != head.pc: sets o_err; still retires normally.
- All arithmetic on pointers and counters wraps; the count never exceeds DEPTH and never underflows.

Test Plan (GHR_LEN=8, DEPTH=4):
- Assert rst asynchronously mid-cycle, no clock edge → o_ghr=0x00, o_arch_ghr=0x00, o_count=0, o_pred_ready=1, o_err=0 immediately.
- Push T,N,T,T from reset, then a 5th push → o_ghr=0x0B, o_count=4, o_pred_ready=0; the 5th push is ignored (o_ghr stays 0x0B).
- From the previous state, feedback T,N,T,T with matching PCs → o_fb_mispredict=0 on each, final o_arch_ghr=0x0B, o_count=0, o_ghr=0x0B, o_err=0.
- Push T,T,T (o_ghr=0x07), then feedback N on the head while also pushing → o_fb_mispredict=1 that cycle; next cycle o_ghr=0x00, o_arch_ghr=0x00, o_count=0; the concurrent push is dropped.
- With o_count=2 and o_ghr=0x03, push N while feedback T is correct → o_count=2, o_ghr=0x06, o_arch_ghr shifts in 1. Then assert i_flush → o_count=0, o_ghr=o_arch_ghr.
- Feedback with o_count=0 → o_err=1 and stays 1; o_arch_ghr unchanged. Feedback with i_fb_pc mismatched → o_err=1 and the head still retires.

Source files
------------

// File: rtl/ghr_checkpoint_unit.sv
// Speculative/architectural global history register with an in-order FIFO of
// per-branch checkpoints used to repair the speculative history on mispredicts.
module ghr_checkpoint_unit #(
    parameter int GHR_LEN    = 8,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_pred_valid,
    input  logic [ADDR_WIDTH-1:0]        i_pred_pc,
    input  logic                         i_pred_taken,
    output logic                         o_pred_ready,
    input  logic                         i_fb_valid,
    input  logic [ADDR_WIDTH-1:0]        i_fb_pc,
    input  logic                         i_fb_taken,
    input  logic                         i_flush,
    output logic [GHR_LEN-1:0]           o_ghr,
    output logic [GHR_LEN-1:0]           o_arch_ghr,
    output logic                         o_fb_mispredict,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic                  pred;
        logic [GHR_LEN-1:0]    ghr_before;
    } entry_t;

    entry_t             r_fifo [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [GHR_LEN-1:0] r_ghr;
    logic [GHR_LEN-1:0] r_arch_ghr;
    logic               r_err;

    entry_t             w_head;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_mispredict;
    logic [GHR_LEN-1:0] w_arch_next;

    assign w_head       = r_fifo[r_head];
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CNT_W'(DEPTH));
    assign w_pop        = i_fb_valid & ~w_empty;
    assign w_mispredict = w_pop & (i_fb_taken != w_head.pred);
    assign w_push       = i_pred_valid & ~w_full & ~w_mispredict & ~i_flush;
    // The oldest bit falls off the top of the history when a new outcome enters.
    assign w_arch_next  = w_pop ? GHR_LEN'({r_arch_ghr, i_fb_taken}) : r_arch_ghr;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_ghr      <= '0;
            r_arch_ghr <= '0;
            r_err      <= 1'b0;
        end else begin
            r_arch_ghr <= w_arch_next;
            if ((i_fb_valid & w_empty) | (w_pop & (i_fb_pc != w_head.pc)))
                r_err <= 1'b1;

            if (w_mispredict) begin
                r_head  <= r_tail;
                r_count <= '0;
                r_ghr   <= GHR_LEN'({w_head.ghr_before, i_fb_taken});
            end else if (i_flush) begin
                r_head  <= r_tail;
                r_count <= '0;
                r_ghr   <= w_arch_next;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + PTR_W'(1);
                    r_ghr  <= GHR_LEN'({r_ghr, i_pred_taken});
                end
                if (w_pop)
                    r_head <= r_head + PTR_W'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // NOTE: checkpoint storage is deliberately not reset; r_count gates every read.
    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_tail] <= '{pc: i_pred_pc, pred: i_pred_taken, ghr_before: r_ghr};
    end

    assign o_pred_ready    = ~w_full;
    assign o_ghr           = r_ghr;
    assign o_arch_ghr      = r_arch_ghr;
    assign o_fb_mispredict = w_mispredict;
    assign o_count         = r_count;
    assign o_err           = r_err;

endmodule

// File: tb/tb_ghr_checkpoint_unit.sv
// Directed bench for ghr_checkpoint_unit (GHR_LEN=8, DEPTH=4) with hand-computed
// expected histories, counts and error flags.
module tb_ghr_checkpoint_unit;

    localparam int GHR_LEN = 8;
    localparam int DEPTH   = 4;
    localparam int AW      = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_pred_valid;
    logic [AW-1:0] i_pred_pc;
    logic          i_pred_taken;
    logic          o_pred_ready;
    logic          i_fb_valid;
    logic [AW-1:0] i_fb_pc;
    logic          i_fb_taken;
    logic          i_flush;
    logic [7:0]    o_ghr;
    logic [7:0]    o_arch_ghr;
    logic          o_fb_mispredict;
    logic [2:0]    o_count;
    logic          o_err;

    int n_cmp = 0;
    int n_mis = 0;

    ghr_checkpoint_unit #(.GHR_LEN(GHR_LEN), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_pred_valid    (i_pred_valid),
        .i_pred_pc       (i_pred_pc),
        .i_pred_taken    (i_pred_taken),
        .o_pred_ready    (o_pred_ready),
        .i_fb_valid      (i_fb_valid),
        .i_fb_pc         (i_fb_pc),
        .i_fb_taken      (i_fb_taken),
        .i_flush         (i_flush),
        .o_ghr           (o_ghr),
        .o_arch_ghr      (o_arch_ghr),
        .o_fb_mispredict (o_fb_mispredict),
        .o_count         (o_count),
        .o_err           (o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to one time unit past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_pred_valid = 1'b0;
        i_pred_pc    = '0;
        i_pred_taken = 1'b0;
        i_fb_valid   = 1'b0;
        i_fb_pc      = '0;
        i_fb_taken   = 1'b0;
        i_flush      = 1'b0;
    endtask

    task automatic push(input logic [AW-1:0] pc, input logic taken);
        i_pred_valid = 1'b1;
        i_pred_pc    = pc;
        i_pred_taken = taken;
    endtask

    task automatic fb(input logic [AW-1:0] pc, input logic taken);
        i_fb_valid = 1'b1;
        i_fb_pc    = pc;
        i_fb_taken = taken;
    endtask

    // Pulse reset between clock edges.
    task automatic pulse_reset();
        #1 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    bit fb_pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        idle();
        #12 rst = 1'b0;
        step();

        // Asynchronous reset mid-cycle, no clock edge in between.
        push(32'h100, 1'b1);
        step();
        idle();
        check("pre_rst_ghr", o_ghr, 8'h01);
        #2 rst = 1'b1;
        #1;
        check("rst_ghr", o_ghr, 8'h00);
        check("rst_arch", o_arch_ghr, 8'h00);
        check("rst_count", o_count, 3'd0);
        check("rst_ready", o_pred_ready, 1'b1);
        check("rst_err", o_err, 1'b0);
        #1 rst = 1'b0;
        step();

        // Fill with T,N,T,T, then a 5th push against a full FIFO.
        for (int i = 0; i < 4; i++) begin
            push(32'h100 + 32'(4 * i), fb_pat[i]);
            step();
        end
        idle();
        check("fill_ghr", o_ghr, 8'h0B);
        check("fill_count", o_count, 3'd4);
        check("fill_ready", o_pred_ready, 1'b0);
        push(32'h110, 1'b1);
        step();
        idle();
        check("full_ghr", o_ghr, 8'h0B);
        check("full_count", o_count, 3'd4);

        // Retire all four correctly.
        for (int i = 0; i < 4; i++) begin
            fb(32'h100 + 32'(4 * i), fb_pat[i]);
            #1;
            check($sformatf("drain_mp%0d", i), o_fb_mispredict, 1'b0);
            step();
        end
        idle();
        check("drain_arch", o_arch_ghr, 8'h0B);
        check("drain_count", o_count, 3'd0);
        check("drain_ghr", o_ghr, 8'h0B);
        check("drain_err", o_err, 1'b0);
        check("drain_ready", o_pred_ready, 1'b1);

        // Misprediction with a concurrent push.
        pulse_reset();
        step();
        for (int i = 0; i < 3; i++) begin
            push(32'h200 + 32'(4 * i), 1'b1);
            step();
        end
        idle();
        check("ttt_ghr", o_ghr, 8'h07);
        fb(32'h200, 1'b0);
        push(32'h20C, 1'b1);
        #1;
        check("mp_flag", o_fb_mispredict, 1'b1);
        step();
        idle();
        check("mp_ghr", o_ghr, 8'h00);
        check("mp_arch", o_arch_ghr, 8'h00);
        check("mp_count", o_count, 3'd0);

        // Concurrent push/pop across the pointer wrap, then flush with a push.
        push(32'h300, 1'b1);
        step();
        push(32'h304, 1'b1);
        step();
        idle();
        check("pp_pre_ghr", o_ghr, 8'h03);
        check("pp_pre_count", o_count, 3'd2);
        push(32'h308, 1'b0);
        fb(32'h300, 1'b1);
        #1;
        check("pp_mp", o_fb_mispredict, 1'b0);
        step();
        idle();
        check("pp_count", o_count, 3'd2);
        check("pp_ghr", o_ghr, 8'h06);
        check("pp_arch", o_arch_ghr, 8'h01);
        i_flush = 1'b1;
        push(32'h30C, 1'b1);
        step();
        idle();
        check("fl_count", o_count, 3'd0);
        check("fl_ghr", o_ghr, 8'h01);
        check("fl_arch", o_arch_ghr, 8'h01);

        // Feedback on an empty FIFO.
        fb(32'h500, 1'b1);
        #1;
        check("empty_mp", o_fb_mispredict, 1'b0);
        step();
        idle();
        check("empty_err", o_err, 1'b1);
        check("empty_arch", o_arch_ghr, 8'h01);
        check("empty_count", o_count, 3'd0);
        step();
        check("err_sticky", o_err, 1'b1);

        // PC mismatch still retires the head.
        pulse_reset();
        step();
        push(32'h400, 1'b1);
        step();
        idle();
        check("pc_pre_err", o_err, 1'b0);
        fb(32'h404, 1'b1);
        step();
        idle();
        check("pc_err", o_err, 1'b1);
        check("pc_count", o_count, 3'd0);
        check("pc_arch", o_arch_ghr, 8'h01);
        check("pc_ghr", o_ghr, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
